seq_pattern_tx: RTL and testbench

Serial bit-pattern transmitter, the generating end of the serial-sequence path that the team's Moore sequence detectors consume. It captures a PAT_W-bit pattern and a repeat count on a start request. It then emits the pattern MSB-first, one bit per clock, back-to-back for the requested number of repetitions, and flags completion. It is a Moore machine: all outputs decode from registered state, and it drives detector inputs in system-level and bench use.

---
 rtl/seq_pattern_tx.sv | 117 +++++++++++
 tb/tb_seq_pattern_tx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first,
// back-to-back for a captured repeat count, then pulses done.
module seq_pattern_tx #(
   parameter int   PAT_W    = 4,
   parameter int   CNT_W    = 8,
   parameter logic IDLE_BIT = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_n,
   input  logic             abort,
   output logic             ready,
   output logic             busy,
   output logic             tx_bit,
   output logic             tx_valid,
   output logic             done
);

   localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(PAT_W - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [PAT_W-1:0] r_pat;
   logic [PAT_W-1:0] r_shift;
   logic [BW-1:0]    r_bit;
   logic [CNT_W-1:0] r_rep;
   logic             r_ready;
   logic             r_busy;
   logic             r_valid;
   logic             r_done;

   logic w_accept;
   logic w_last;

   // A zero repeat count is dropped so rep_cnt can never underflow.
   assign w_accept = start && !abort && (repeat_n != '0);
   assign w_last   = (r_bit == LAST_BIT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_pat   <= '0;
         r_shift <= '0;
         r_bit   <= '0;
         r_rep   <= '0;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state <= S_SHIFT;
                  r_pat   <= pattern;
                  r_shift <= pattern;
                  r_bit   <= '0;
                  r_rep   <= repeat_n;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
                  r_valid <= 1'b1;
               end
            end
            S_SHIFT: begin
               if (abort) begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
                  r_valid <= 1'b0;
               end else if (w_last) begin
                  if (r_rep > CNT_W'(1)) begin
                     // Reload without a gap so repetitions stay contiguous.
                     r_shift <= r_pat;
                     r_bit   <= '0;
                     r_rep   <= r_rep - CNT_W'(1);
                  end else begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end else begin
                  r_shift <= {r_shift[PAT_W-2:0], 1'b0};
                  r_bit   <= r_bit + BW'(1);
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
               r_valid <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign ready    = r_ready;
   assign busy     = r_busy;
   assign tx_valid = r_valid;
   assign done     = r_done;
   assign tx_bit   = (r_state == S_SHIFT) ? r_shift[PAT_W-1] : IDLE_BIT;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: vector table, directed corner cases,
// and random traffic against a queue-based bit-stream model.
module tb_seq_pattern_tx;

   localparam int PAT_W = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [PAT_W-1:0] pattern;
   logic [CNT_W-1:0] repeat_n;
   logic             abort;
   logic             ready;
   logic             busy;
   logic             tx_bit;
   logic             tx_valid;
   logic             done;

   seq_pattern_tx #(
      .PAT_W(PAT_W),
      .CNT_W(CNT_W),
      .IDLE_BIT(1'b0)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .pattern(pattern),
      .repeat_n(repeat_n),
      .abort(abort),
      .ready(ready),
      .busy(busy),
      .tx_bit(tx_bit),
      .tx_valid(tx_valid),
      .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: the remaining bits of the transfer, plus a pending done flag.
   bit q[$];
   bit m_done = 1'b0;

   typedef struct {
      logic             st;
      logic [PAT_W-1:0] pat;
      logic [CNT_W-1:0] rep;
      logic             ab;
      logic             rdy;
      logic             bsy;
      logic             vld;
      logic             bt;
      logic             dn;
   } vec_t;

   vec_t tbl[9];

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      if (!reset) begin
         q.delete();
         m_done = 1'b0;
      end else if (q.size() != 0) begin
         if (abort) q.delete();
         else begin
            q.delete(0);
            if (q.size() == 0) m_done = 1'b1;
         end
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (start && !abort && repeat_n != 0) begin
         for (int r = 0; r < int'(repeat_n); r++)
            for (int i = PAT_W - 1; i >= 0; i--)
               q.push_back(pattern[i]);
      end
   endtask

   task automatic check_model(string tag);
      logic v;
      logic b;
      v = (q.size() != 0);
      b = v ? logic'(q[0]) : 1'b0;
      check({tag, ".valid"}, 32'(tx_valid), 32'(v));
      check({tag, ".bit"}, 32'(tx_bit), 32'(b));
      check({tag, ".busy"}, 32'(busy), 32'(v));
      check({tag, ".done"}, 32'(done), 32'(m_done));
      check({tag, ".ready"}, 32'(ready), 32'(!v && !m_done));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_in(logic s, logic [PAT_W-1:0] p,
                         logic [CNT_W-1:0] r, logic a);
      start    = s;
      pattern  = p;
      repeat_n = r;
      abort    = a;
   endtask

   initial begin
      int n_bits;
      int n_done;
      int n_match;
      int n_valid;
      logic [3:0]  win;
      logic [11:0] stream;
      bit seen_done;

      tbl[0] = '{1'b1, 4'h0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 4'hA, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 4'hA, 8'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 4'h5, 8'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 4'h0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 4'h0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 4'h0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[7] = '{1'b1, 4'hF, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[8] = '{1'b0, 4'h0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

      reset = 1'b0;
      set_in(1'b0, '0, '0, 1'b0);
      #12;
      check("rst.ready", 32'(ready), 32'd1);
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.valid", 32'(tx_valid), 32'd0);
      check("rst.done", 32'(done), 32'd0);
      check("rst.bit", 32'(tx_bit), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (3) begin
         cyc();
         check_model("idle");
      end

      for (int k = 0; k < 9; k++) begin
         set_in(tbl[k].st, tbl[k].pat, tbl[k].rep, tbl[k].ab);
         cyc();
         check($sformatf("tbl%0d.ready", k), 32'(ready), 32'(tbl[k].rdy));
         check($sformatf("tbl%0d.busy", k), 32'(busy), 32'(tbl[k].bsy));
         check($sformatf("tbl%0d.valid", k), 32'(tx_valid), 32'(tbl[k].vld));
         check($sformatf("tbl%0d.bit", k), 32'(tx_bit), 32'(tbl[k].bt));
         check($sformatf("tbl%0d.done", k), 32'(done), 32'(tbl[k].dn));
      end

      set_in(1'b1, 4'hA, 8'd3, 1'b0);
      cyc();
      set_in(1'b0, 4'h0, 8'd0, 1'b0);
      n_bits  = 0;
      n_done  = 0;
      n_match = 0;
      win     = '0;
      stream  = '0;
      for (int k = 0; k < 16; k++) begin
         check_model("det");
         if (tx_valid) begin
            n_bits++;
            win    = {win[2:0], tx_bit};
            stream = {stream[10:0], tx_bit};
            if (n_bits >= 4 && win == 4'b1010) n_match++;
         end
         if (done) n_done++;
         cyc();
      end
      check("det.bits", 32'(n_bits), 32'd12);
      check("det.stream", 32'(stream), 32'hAAA);
      check("det.matches", 32'(n_match), 32'd5);
      check("det.done_pulses", 32'(n_done), 32'd1);

      set_in(1'b1, 4'hC, 8'd2, 1'b0);
      cyc();
      check("abt.b0", 32'(tx_bit), 32'd1);
      set_in(1'b0, 4'h0, 8'd0, 1'b0);
      cyc();
      check("abt.b1", 32'(tx_bit), 32'd1);
      cyc();
      check("abt.b2", 32'(tx_bit), 32'd0);
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      check("abt.valid", 32'(tx_valid), 32'd0);
      check("abt.ready", 32'(ready), 32'd1);
      check("abt.done", 32'(done), 32'd0);
      set_in(1'b1, 4'h6, 8'd1, 1'b0);
      cyc();
      set_in(1'b0, 4'h0, 8'd0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         check_model("abt.next");
         cyc();
      end

      set_in(1'b1, 4'hC, 8'd2, 1'b0);
      cyc();
      set_in(1'b0, 4'h0, 8'd0, 1'b0);
      cyc();
      #3;
      reset = 1'b0;
      #1;
      check("arst.ready", 32'(ready), 32'd1);
      check("arst.busy", 32'(busy), 32'd0);
      check("arst.valid", 32'(tx_valid), 32'd0);
      check("arst.done", 32'(done), 32'd0);
      check("arst.bit", 32'(tx_bit), 32'd0);
      cyc();
      cyc();
      reset = 1'b1;
      cyc();
      check_model("arst.idle");
      set_in(1'b1, 4'h6, 8'd1, 1'b0);
      cyc();
      set_in(1'b0, 4'h0, 8'd0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         check_model("arst.next");
         cyc();
      end

      set_in(1'b1, 4'h9, 8'd255, 1'b0);
      cyc();
      set_in(1'b0, 4'h0, 8'd0, 1'b0);
      n_valid   = 0;
      seen_done = 1'b0;
      for (int k = 0; k < 1100 && !seen_done; k++) begin
         check_model("max");
         if (tx_valid) n_valid++;
         if (done) seen_done = 1'b1;
         cyc();
      end
      check("max.valid_cycles", 32'(n_valid), 32'd1020);
      check("max.done_seen", 32'(seen_done), 32'd1);

      for (int k = 0; k < 3000; k++) begin
         set_in(($urandom % 3) == 0, PAT_W'($urandom),
                CNT_W'($urandom % 4), ($urandom % 40) == 0);
         cyc();
         check_model("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
